// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall vector, branch flush, fetch discard and wait watchdog.
// Define STALL_PERF_EN to build the stall-cycle and flush performance counters.
module stall_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall_req,
  input  logic        if_done,
  input  logic        mem_stall_req,
  input  logic        mem_done,
  input  logic        id_stall_req,
  input  logic        ex_jump_flag,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        discard_fetch,
  output logic        timeout_err,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
);

  localparam int unsigned STALL_W = 6;
  localparam logic [STALL_W-1:0] PAT_IF  = 6'b000011;
  localparam logic [STALL_W-1:0] PAT_MEM = 6'b011111;
  localparam logic [STALL_W-1:0] PAT_ID  = 6'b000111;
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {RUN, WAIT_IF, WAIT_MEM, WAIT_BOTH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             jump_pending, jump_pending_nxt;
  logic             timeout_nxt;
  logic             if_hold, mem_hold;
  logic             if_next, mem_next;

  // Next state, stall/flush/discard decode and watchdog update
  always_comb begin
    state_nxt        = state;
    if_hold          = 1'b0;
    mem_hold         = 1'b0;
    if_next          = 1'b0;
    mem_next         = 1'b0;
    stall            = '0;
    flush            = 1'b0;
    discard_fetch    = 1'b0;
    jump_pending_nxt = jump_pending;
    cnt_nxt          = cnt;
    timeout_nxt      = timeout_err;

    // A done releases its wait in the same cycle; a new request in RUN stalls at once
    unique case (state)
      RUN: begin
        if_hold  = if_stall_req;
        mem_hold = mem_stall_req;
        if_next  = if_stall_req & ~if_done;
        mem_next = mem_stall_req & ~mem_done;
      end
      WAIT_IF: begin
        if_hold  = ~if_done;
        if_next  = ~if_done;
        mem_next = mem_stall_req & ~mem_done;
      end
      WAIT_MEM: begin
        mem_hold = ~mem_done;
        mem_next = ~mem_done;
        if_next  = if_stall_req & ~if_done;
      end
      WAIT_BOTH: begin
        if_hold  = ~if_done;
        mem_hold = ~mem_done;
        if_next  = ~if_done;
        mem_next = ~mem_done;
      end
      default: ;
    endcase

    unique case ({mem_next, if_next})
      2'b11:   state_nxt = WAIT_BOTH;
      2'b10:   state_nxt = WAIT_MEM;
      2'b01:   state_nxt = WAIT_IF;
      default: state_nxt = RUN;
    endcase

    if (if_hold)      stall = stall | PAT_IF;
    if (mem_hold)     stall = stall | PAT_MEM;
    if (id_stall_req) stall = stall | PAT_ID;
    stall[5] = 1'b0;

    flush         = ex_jump_flag & ~stall[3];
    discard_fetch = if_done & (jump_pending | flush);

    // A fetch already in flight when the branch resolves returns wrong-path data
    if (if_done)
      jump_pending_nxt = 1'b0;
    else if (flush && (state == WAIT_IF || state == WAIT_BOTH))
      jump_pending_nxt = 1'b1;

    if (state == RUN)
      cnt_nxt = '0;
    else if (cnt != CNT_MAX)
      cnt_nxt = cnt + CNT_W'(1);
    timeout_nxt = timeout_err | (cnt_nxt == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RUN;
      cnt          <= '0;
      jump_pending <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      jump_pending <= jump_pending_nxt;
      timeout_err  <= timeout_nxt;
    end
  end

`ifdef STALL_PERF_EN
  // Free-running event counters, wrap modulo 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + 32'(stall[0]);
      perf_flushes      <= perf_flushes + 32'(flush);
    end
  end
`else
  assign perf_stall_cycles = '0;
  assign perf_flushes      = '0;
`endif

endmodule
